// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FP issue/hazard controller.
// Imported by the scoreboard and the top-level issue controller.
package fpu_ctrl_pkg;

  localparam int unsigned REG_W          = 5;
  localparam int unsigned DIV_CYCLES_DEF = 12;
  localparam int unsigned PIPE_DEPTH_DEF = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_WB   = 2'd2
  } fpu_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_slot_t;

endpackage

// File: rtl/fpu_scoreboard.sv
// In-flight FP destination tracker: a shift register from PRE to WB plus the
// RAW comparators for both source operands.
module fpu_scoreboard
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  sb_slot_t         i_load,
  input  sb_slot_t         i_div,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_use_rs1,
  input  logic             i_use_rs2,
  output logic             o_raw,
  output logic             o_pre_valid,
  output sb_slot_t         o_wb
);

  sb_slot_t r_sb [PIPE_DEPTH];
  logic     w_hit1;
  logic     w_hit2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) r_sb[i] <= '0;
    end else begin
      r_sb[0] <= i_load;
      for (int i = 1; i < PIPE_DEPTH; i++) r_sb[i] <= r_sb[i-1];
    end
  end

  // The WB slot is excluded: the regfile writes through to the same-cycle read.
  always_comb begin
    w_hit1 = i_div.valid & (i_div.rd == i_rs1);
    w_hit2 = i_div.valid & (i_div.rd == i_rs2);
    for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
      w_hit1 = w_hit1 | (r_sb[i].valid & (r_sb[i].rd == i_rs1));
      w_hit2 = w_hit2 | (r_sb[i].valid & (r_sb[i].rd == i_rs2));
    end
  end

  assign o_raw       = (i_use_rs1 & w_hit1) | (i_use_rs2 & w_hit2);
  assign o_pre_valid = r_sb[0].valid;
  assign o_wb        = r_sb[PIPE_DEPTH-1];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: gates ID->PRE issue on RAW and structural hazards and
// sequences the multi-cycle divider, which owns EX while it runs.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic             i_id_fregWrite,
  input  logic [REG_W-1:0] i_id_fRs1,
  input  logic [REG_W-1:0] i_id_fRs2,
  input  logic [REG_W-1:0] i_id_fRd,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_is_div,
  input  logic             i_flush,
  output logic             o_issue,
  output logic             o_stall,
  output logic             o_pre_bubble,
  output logic             o_div_busy,
  output logic             o_div_done,
  output logic [REG_W-1:0] o_div_wb_rd
);

  localparam int unsigned CntW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  fpu_state_e      r_state;
  fpu_state_e      w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  sb_slot_t        r_div;
  sb_slot_t        w_div_nxt;

  sb_slot_t w_load;
  sb_slot_t w_div_cmp;
  sb_slot_t w_wb;
  logic     w_raw;
  logic     w_pre_valid;
  logic     w_struct;
  logic     w_issue;
  logic     w_unused_wb;

  assign w_load    = {w_issue & i_id_fregWrite & ~i_id_is_div, i_id_fRd};
  assign w_div_cmp = {r_div.valid & (r_state != DIV_WB), r_div.rd};

  fpu_scoreboard #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_div       (w_div_cmp),
    .i_rs1       (i_id_fRs1),
    .i_rs2       (i_id_fRs2),
    .i_use_rs1   (i_id_use_rs1),
    .i_use_rs2   (i_id_use_rs2),
    .o_raw       (w_raw),
    .o_pre_valid (w_pre_valid),
    .o_wb        (w_wb)
  );

  // Slot-2 tag only matters for regfile port debug; the divide never collides with it.
  assign w_unused_wb = ^w_wb;

  // With a 2-cycle divide, an instruction now in PRE would reach WB alongside div_done.
  assign w_struct = (r_state != RUN) |
                    ((DIV_CYCLES == 2) & i_id_is_div & w_pre_valid);
  assign w_issue  = i_id_valid & ~i_flush & ~w_raw & ~w_struct & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    unique case (r_state)
      RUN: begin
        if (w_issue & i_id_is_div) begin
          w_state_nxt = DIV_WAIT;
          w_cnt_nxt   = CntW'(DIV_CYCLES - 2);
          w_div_nxt   = {i_id_fregWrite, i_id_fRd};
        end
      end
      DIV_WAIT: begin
        if (r_cnt == '0) w_state_nxt = DIV_WB;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      DIV_WB: begin
        w_state_nxt     = RUN;
        w_div_nxt.valid = 1'b0;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    o_issue      = w_issue;
    o_stall      = i_id_valid & ~i_flush & ~w_issue & ~i_rst;
    o_pre_bubble = ~w_issue;
    o_div_busy   = (r_state != RUN) & ~i_rst;
    o_div_done   = (r_state == DIV_WB) & ~i_rst;
    o_div_wb_rd  = o_div_done ? r_div.rd : '0;
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with DIV_CYCLES=12.
module tb_fpu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_fregWrite, id_use_rs1, id_use_rs2, id_is_div, flush;
  logic [4:0] id_fRs1, id_fRs2, id_fRd;
  logic       issue, stall, pre_bubble, div_busy, div_done;
  logic [4:0] div_wb_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .DIV_CYCLES (12),
    .PIPE_DEPTH (3)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_valid     (id_valid),
    .i_id_fregWrite (id_fregWrite),
    .i_id_fRs1      (id_fRs1),
    .i_id_fRs2      (id_fRs2),
    .i_id_fRd       (id_fRd),
    .i_id_use_rs1   (id_use_rs1),
    .i_id_use_rs2   (id_use_rs2),
    .i_id_is_div    (id_is_div),
    .i_flush        (flush),
    .o_issue        (issue),
    .o_stall        (stall),
    .o_pre_bubble   (pre_bubble),
    .o_div_busy     (div_busy),
    .o_div_done     (div_done),
    .o_div_wb_rd    (div_wb_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_fregWrite = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_div = 0; flush = 0; id_fRs1 = 0; id_fRs2 = 0; id_fRd = 0;
  endtask

  task automatic present(input logic fw, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic dv);
    id_valid = 1; id_fregWrite = fw; id_fRs1 = rs1; id_fRs2 = rs2; id_fRd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_is_div = dv; flush = 0;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    idle();
    rst = 1;
    present(1, 5'd1, 5'd2, 5'd3, 1, 1, 0);
    tick(); tick();
    chk("rst_issue", issue, 0);
    chk("rst_stall", stall, 0);
    chk("rst_bubble", pre_bubble, 1);
    chk("rst_busy", div_busy, 0);
    chk("rst_done", div_done, 0);
    chk("rst_wbrd", div_wb_rd, 0);
    rst = 0;
    idle_cycles(1);

    // RAW: fadd f3 at t0, dependent fmul f4<-f3,f5 from t1
    present(1, 5'd1, 5'd2, 5'd3, 1, 1, 0);
    #1 chk("raw_t0_issue", issue, 1);
    tick();
    present(1, 5'd3, 5'd5, 5'd4, 1, 1, 0);
    #1 chk("raw_t1_stall", stall, 1);
    chk("raw_t1_bubble", pre_bubble, 1);
    chk("raw_t1_issue", issue, 0);
    tick();
    #1 chk("raw_t2_stall", stall, 1);
    chk("raw_t2_bubble", pre_bubble, 1);
    tick();
    #1 chk("raw_t3_issue", issue, 1);
    chk("raw_t3_stall", stall, 0);
    chk("raw_t3_bubble", pre_bubble, 0);
    tick();
    idle_cycles(3);

    // Independent back-to-back stream
    present(1, 5'd8, 5'd9, 5'd1, 1, 1, 0);
    #1 chk("ind0_issue", issue, 1);
    chk("ind0_stall", stall, 0);
    tick();
    present(1, 5'd10, 5'd11, 5'd2, 1, 1, 0);
    #1 chk("ind1_issue", issue, 1);
    chk("ind1_stall", stall, 0);
    tick();
    present(1, 5'd12, 5'd13, 5'd6, 1, 1, 0);
    #1 chk("ind2_issue", issue, 1);
    chk("ind2_stall", stall, 0);
    tick();
    // Matching rs1 but not read: no hazard
    present(1, 5'd6, 5'd14, 5'd9, 0, 1, 0);
    #1 chk("unused_rs1_issue", issue, 1);
    tick();
    idle_cycles(3);

    // fdiv f7, with an fadd waiting from t1
    present(1, 5'd14, 5'd15, 5'd7, 1, 1, 1);
    #1 chk("div_t0_issue", issue, 1);
    chk("div_t0_busy", div_busy, 0);
    tick();
    for (int k = 1; k <= 12; k++) begin
      present(1, 5'd21, 5'd22, 5'd20, 1, 1, 0);
      #1 chk($sformatf("div_t%0d_busy", k), div_busy, 1);
      chk($sformatf("div_t%0d_stall", k), stall, 1);
      chk($sformatf("div_t%0d_done", k), div_done, (k == 12) ? 1 : 0);
      chk($sformatf("div_t%0d_wbrd", k), div_wb_rd, (k == 12) ? 7 : 0);
      tick();
    end
    #1 chk("div_t13_issue", issue, 1);
    chk("div_t13_busy", div_busy, 0);
    chk("div_t13_done", div_done, 0);
    tick();
    idle_cycles(3);

    // fsw reading f7 behind a divide of f7
    present(1, 5'd14, 5'd15, 5'd7, 1, 1, 1);
    #1 chk("fsw_div_issue", issue, 1);
    tick();
    for (int k = 1; k <= 12; k++) begin
      present(0, 5'd0, 5'd7, 5'd0, 0, 1, 0);
      #1 chk($sformatf("fsw_t%0d_stall", k), stall, 1);
      tick();
    end
    #1 chk("fsw_t13_issue", issue, 1);
    tick();
    // fsw writes nothing, so a reader of f0 is not held
    present(1, 5'd0, 5'd7, 5'd1, 1, 1, 0);
    #1 chk("fsw_nowrite_issue", issue, 1);
    tick();
    idle_cycles(3);

    // flush beats a hazard; scoreboard keeps shifting
    present(1, 5'd1, 5'd2, 5'd9, 1, 1, 0);
    #1 chk("fl_t0_issue", issue, 1);
    tick();
    present(1, 5'd9, 5'd3, 5'd10, 1, 1, 0);
    flush = 1;
    #1 chk("fl_t1_issue", issue, 0);
    chk("fl_t1_stall", stall, 0);
    chk("fl_t1_bubble", pre_bubble, 1);
    tick();
    flush = 0;
    #1 chk("fl_t2_stall", stall, 1);
    tick();
    #1 chk("fl_t3_issue", issue, 1);
    tick();
    idle_cycles(3);

    // Reset in the middle of a divide
    present(1, 5'd14, 5'd15, 5'd7, 1, 1, 1);
    #1 chk("rd_t0_issue", issue, 1);
    tick();
    idle();
    for (int k = 1; k <= 4; k++) begin
      #1 chk($sformatf("rd_t%0d_busy", k), div_busy, 1);
      tick();
    end
    rst = 1;
    #1 chk("rd_t5_busy", div_busy, 0);
    chk("rd_t5_issue", issue, 0);
    chk("rd_t5_bubble", pre_bubble, 1);
    tick();
    rst = 0;
    present(1, 5'd7, 5'd1, 5'd3, 1, 1, 0);
    #1 chk("rd_t6_issue", issue, 1);
    chk("rd_t6_busy", div_busy, 0);
    tick();
    idle();
    for (int k = 7; k <= 20; k++) begin
      #1 chk($sformatf("rd_t%0d_done", k), div_done, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
